// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI row capture controller.
// Capture FSM states and sticky error bit positions.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } cap_state_t;

    localparam int ERR_SHORT   = 0;
    localparam int ERR_BAD_ROW = 1;
    localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/spi_idle_watchdog.sv
// Idle-cycle watchdog for the PAYLOAD phase.
// Only built when SPI_TIMEOUT_EN is defined.
`ifdef SPI_TIMEOUT_EN
module spi_idle_watchdog #(
    parameter int  TIMEOUT_CYCLES = 10000,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive enabled cycle without a kick.
    assign expired = enable && !kick
                  && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (kick || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/spi_row_capture_ctrl.sv
// Turns CS-framed SPI bursts (row header + payload) into frame-buffer writes.
// Optional PAYLOAD idle timeout is built with SPI_TIMEOUT_EN.
module spi_row_capture_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH     = 8,
    parameter int  LINES          = 1,
    parameter int  ROW_WORDS      = 320,
    parameter int  ROWS           = 180,
    parameter int  TIMEOUT_CYCLES = 10000,
    localparam int ADDR_WIDTH     = $clog2(ROWS * ROW_WORDS)
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [LINES-1:0][DATA_WIDTH-1:0] word_in,
    input  logic                             word_valid_in,
    input  logic                             chip_sel_in,
    output logic [ADDR_WIDTH-1:0]            wr_addr_out,
    output logic [LINES*DATA_WIDTH-1:0]      wr_data_out,
    output logic                             wr_en_out,
    output logic                             frame_done_out,
    output logic                             busy_out,
    output logic [2:0]                       err_out
);

    localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    cap_state_t                  state_q, state_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [2:0]                  err_d;
    logic                        wr_en_d, done_d;
    logic [ADDR_WIDTH-1:0]       wr_addr_d;
    logic [LINES*DATA_WIDTH-1:0] wr_data_d;
    logic                        cs_q;
    logic                        cs_fall, cs_rise;
    logic                        hdr_ok, last_col, last_row;
    logic                        tmo_expired;

    assign cs_fall  = cs_q && !chip_sel_in;
    assign cs_rise  = !cs_q && chip_sel_in;
    assign hdr_ok   = 32'(word_in[0]) < 32'(ROWS);
    assign last_col = col_q == COL_W'(ROW_WORDS - 1);
    assign last_row = row_q == ROW_W'(ROWS - 1);
    assign busy_out = (state_q == HEADER) || (state_q == PAYLOAD);

`ifdef SPI_TIMEOUT_EN
    spi_idle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .kick    (word_valid_in),
        .enable  (state_q == PAYLOAD),
        .expired (tmo_expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = TIMEOUT_CYCLES != 0;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        err_d     = err_out;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        wr_addr_d = wr_addr_out;
        wr_data_d = wr_data_out;
        // The word is consumed first; CS edges then act on the updated state.
        unique case (state_q)
            HEADER: begin
                if (word_valid_in) begin
                    row_d = ROW_W'(word_in[0]);
                    col_d = '0;
                    if (hdr_ok) begin
                        state_d = PAYLOAD;
                    end else begin
                        err_d[ERR_BAD_ROW] = 1'b1;
                        state_d            = DRAIN;
                    end
                end
            end
            PAYLOAD: begin
                if (word_valid_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(ROW_WORDS)
                              + ADDR_WIDTH'(col_q);
                    wr_data_d = word_in;
                    col_d     = col_q + COL_W'(1);
                    if (last_col) begin
                        state_d = DRAIN;
                        done_d  = last_row;
                    end
                end else if (tmo_expired) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = DRAIN;
                end
            end
            default: ;
        endcase
        if (cs_rise) begin
            if (state_d == HEADER || state_d == PAYLOAD) begin
                err_d[ERR_SHORT] = 1'b1;
            end
            state_d = IDLE;
        end else if (cs_fall) begin
            if (state_d == PAYLOAD) begin
                err_d[ERR_SHORT] = 1'b1;
            end
            state_d = HEADER;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            cs_q           <= 1'b1;
            err_out        <= '0;
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            cs_q           <= chip_sel_in;
            err_out        <= err_d;
            wr_en_out      <= wr_en_d;
            frame_done_out <= done_d;
            wr_addr_out    <= wr_addr_d;
            wr_data_out    <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_spi_row_capture_ctrl.sv
// Randomized burst-level check of spi_row_capture_ctrl against a row model.
// Timeout scenario runs only when SPI_TIMEOUT_EN is defined.
module tb_spi_row_capture_ctrl;

    localparam int DW   = 8;
    localparam int LN   = 2;
    localparam int RW   = 4;
    localparam int NR   = 3;
    localparam int TMO  = 50;
    localparam int AW   = $clog2(NR * RW);

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          done;
        int            cyc;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [LN-1:0][DW-1:0] word = '0;
    logic                 word_valid = 1'b0;
    logic                 chip_sel = 1'b1;
    logic [AW-1:0]        wr_addr;
    logic [LN*DW-1:0]     wr_data;
    logic                 wr_en, frame_done, busy;
    logic [2:0]           err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [2:0] err_exp = '0;
    wr_t  got_q[$];

    spi_row_capture_ctrl #(
        .DATA_WIDTH    (DW),
        .LINES         (LN),
        .ROW_WORDS     (RW),
        .ROWS          (NR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .word_in       (word),
        .word_valid_in (word_valid),
        .chip_sel_in   (chip_sel),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .wr_en_out     (wr_en),
        .frame_done_out(frame_done),
        .busy_out      (busy),
        .err_out       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got_q.push_back('{addr: wr_addr, data: wr_data,
                              done: frame_done, cyc: cyc});
        end
        if (rst_n && frame_done && !wr_en) begin
            chk("done_without_wr", {31'b0, wr_en}, 32'd1);
        end
    end

    task automatic drive_cycle(input bit v, input logic [15:0] w,
                               input bit cs);
        @(negedge clk);
        word_valid = v;
        word       = w;
        chip_sel   = cs;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        word_valid = 1'b0;
        chip_sel   = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_done", {31'b0, frame_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {29'b0, err}, 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        rst_n   = 1'b1;
        err_exp = '0;
        got_q.delete();
    endtask

    // One CS-low burst: header hdr, then n payload words.
    task automatic run_burst(input int hdr, input int n, input bit same,
                             input bit fixed);
        logic [15:0] words[$];
        int          wcyc[$];
        wr_t         exp_q[$];
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'(17 * (i + 1));
            words.push_back(fixed ? {b, b} : 16'($urandom));
        end
        if (hdr < NR) begin
            for (int i = 0; i < n && i < RW; i++) begin
                exp_q.push_back('{addr: AW'(hdr * RW + i), data: words[i],
                                  done: (hdr == NR - 1) && (i == RW - 1),
                                  cyc: 0});
            end
            if (n < RW) err_exp[0] = 1'b1;
        end else begin
            err_exp[1] = 1'b1;
        end
        got_q.delete();
        drive_cycle(0, '0, 0);
        drive_cycle(1, {8'($urandom), 8'(hdr)}, same && n == 0);
        chk("busy_in_burst", {31'b0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive_cycle(0, '0, 0);
            drive_cycle(1, words[i], same && i == n - 1);
            wcyc.push_back(cyc);
        end
        if (!same) begin
            drive_cycle(0, '0, 0);
            drive_cycle(0, '0, 1);
        end
        repeat (3) drive_cycle(0, '0, 1);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("err", {29'b0, err}, {29'b0, err_exp});
        chk("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("wr_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
            chk("wr_data", 32'(got_q[i].data), 32'(exp_q[i].data));
            chk("wr_done", {31'b0, got_q[i].done}, {31'b0, exp_q[i].done});
            chk("wr_latency", got_q[i].cyc, wcyc[i] + 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        run_burst(1, 4, 0, 1);
        run_burst(2, 4, 0, 1);
        run_burst(0, 2, 0, 1);
        do_reset();
        run_burst(3, 4, 0, 1);
        do_reset();
        run_burst(1, 4, 1, 1);
        run_burst(0, 6, 0, 0);
        run_burst(2, 6, 1, 0);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            run_burst($urandom_range(0, NR), $urandom_range(0, RW + 2),
                      1'($urandom_range(0, 1)), 0);
        end
        // Reset in the middle of a payload.
        do_reset();
        drive_cycle(0, '0, 0);
        drive_cycle(1, 16'h0001, 0);
        drive_cycle(1, 16'h1234, 0);
        drive_cycle(1, 16'h5678, 0);
        do_reset();
`ifdef SPI_TIMEOUT_EN
        drive_cycle(0, '0, 0);
        drive_cycle(1, 16'h0000, 0);
        drive_cycle(1, 16'hABCD, 0);
        repeat (TMO) drive_cycle(0, '0, 0);
        chk("tmo_err_early", {29'b0, err}, 32'd0);
        chk("tmo_busy_early", {31'b0, busy}, 32'd1);
        drive_cycle(0, '0, 0);
        chk("tmo_err", {29'b0, err}, 32'b100);
        chk("tmo_busy", {31'b0, busy}, 32'd0);
        repeat (3) drive_cycle(0, '0, 1);
        chk("tmo_err_sticky", {29'b0, err}, 32'b100);
        drive_cycle(0, '0, 0);
        drive_cycle(1, 16'h0001, 0);
        drive_cycle(1, 16'h4444, 0);
        do_reset();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
